// File: rtl/fir_out_pkg.sv
// Shared constants and helpers for the FIR output stage: default widths,
// saturation limits and the event-counter width.
package fir_out_pkg;

    localparam int DIN_W_DEF  = 39;
    localparam int DOUT_W_DEF = 16;
    localparam int SHIFT_DEF  = 19;
    localparam int DEPTH_DEF  = 4;
    localparam int CNT_W      = 8;

    localparam logic [DOUT_W_DEF-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [DOUT_W_DEF-1:0] SAT_MIN = 16'h8000;

    // Saturating event counter; an event in the clear cycle still counts once.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                  input logic             ev,
                                                  input logic             clr);
        if (clr) return ev ? CNT_W'(1) : '0;
        if (ev && cnt != '1) return cnt + CNT_W'(1);
        return cnt;
    endfunction

endpackage

// File: rtl/fir_out_stage_if.sv
// Sample-side bus of the FIR output stage: accumulator input, valid/ready
// sample output and the status/flag group.
interface fir_out_stage_if
    import fir_out_pkg::*;
#(
    parameter int DIN_W  = DIN_W_DEF,
    parameter int DOUT_W = DOUT_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
);
    logic signed [DIN_W-1:0]      din;
    logic                         din_valid;
    logic        [DOUT_W-1:0]     dout;
    logic                         dout_valid;
    logic                         dout_ready;
    logic [$clog2(DEPTH):0]       fifo_level;
    logic                         sat_flag;
    logic                         drop_flag;
    logic                         clr_flags;
    logic        [CNT_W-1:0]      sat_cnt;
    logic        [CNT_W-1:0]      drop_cnt;

    modport master (
        output din, din_valid, dout_ready, clr_flags,
        input  dout, dout_valid, fifo_level, sat_flag, drop_flag, sat_cnt, drop_cnt
    );

    modport slave (
        input  din, din_valid, dout_ready, clr_flags,
        output dout, dout_valid, fifo_level, sat_flag, drop_flag, sat_cnt, drop_cnt
    );

endinterface

// File: rtl/fir_out_fifo.sv
// First-word-fall-through FIFO; an extra pointer MSB separates full from empty.
// A write into a full FIFO is accepted only when a read happens the same cycle.
module fir_out_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [DW-1:0]           wr_data,
    input  logic                    rd_en,
    output logic [DW-1:0]           rd_data,
    output logic                    empty,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  level
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          do_wr, do_rd;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level   = wr_ptr_q - rd_ptr_q;
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_wr);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_rd);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/fir_out_stage.sv
// FIR output stage: round half-up, saturate to DOUT_W, buffer in a FWFT FIFO.
// Define FIR_OUT_STATS_EN to build the saturating sat/drop event counters.
module fir_out_stage
    import fir_out_pkg::*;
#(
    parameter int DIN_W  = DIN_W_DEF,
    parameter int DOUT_W = DOUT_W_DEF,
    parameter int SHIFT  = SHIFT_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic            clk,
    input  logic            reset,
    fir_out_stage_if.slave  bus
);
    localparam int QW = DIN_W + 1 - SHIFT;
    localparam logic signed [DIN_W:0]    RND     = (DIN_W+1)'(1) << (SHIFT - 1);
    localparam logic signed [QW-1:0]     Q_HI    = QW'((longint'(1) <<< (DOUT_W - 1)) - 1);
    localparam logic signed [QW-1:0]     Q_LO    = ~Q_HI;
    localparam logic signed [DOUT_W-1:0] OUT_MAX = {1'b0, {(DOUT_W-1){1'b1}}};
    localparam logic signed [DOUT_W-1:0] OUT_MIN = {1'b1, {(DOUT_W-1){1'b0}}};

    // One guard bit keeps the rounding add from overflowing.
    function automatic logic signed [DIN_W:0] round_half_up(input logic signed [DIN_W-1:0] d);
        return {d[DIN_W-1], d} + RND;
    endfunction

    function automatic logic signed [QW-1:0] shr_q(input logic signed [DIN_W:0] s);
        return QW'(s >>> SHIFT);
    endfunction

    function automatic logic is_clip(input logic signed [QW-1:0] q);
        return (q > Q_HI) || (q < Q_LO);
    endfunction

    function automatic logic signed [DOUT_W-1:0] saturate(input logic signed [QW-1:0] q);
        if (q > Q_HI) return OUT_MAX;
        if (q < Q_LO) return OUT_MIN;
        return q[DOUT_W-1:0];
    endfunction

    logic signed [DIN_W:0]    sum_p1_q, sum_p1_d;
    logic                     vld_p1_q;
    logic signed [QW-1:0]     q_p1;
    logic signed [DOUT_W-1:0] res_p2_q, res_p2_d;
    logic                     sat_p2_q, sat_p2_d;
    logic                     vld_p2_q;
    logic                     fifo_empty, fifo_full, rd_en;
    logic [DOUT_W-1:0]        fifo_rd;
    logic                     sat_ev, drop_ev;
    logic                     sat_flag_q, sat_flag_d;
    logic                     drop_flag_q, drop_flag_d;

    // Stage 1: rounding offset added on the sign-extended accumulator
    always_comb begin
        sum_p1_d = round_half_up(bus.din);
    end

    // Stage 2: drop fractional bits and clip to the output range
    always_comb begin
        q_p1     = shr_q(sum_p1_q);
        res_p2_d = saturate(q_p1);
        sat_p2_d = vld_p1_q && is_clip(q_p1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_p1_q <= '0;
            vld_p1_q <= 1'b0;
            res_p2_q <= '0;
            sat_p2_q <= 1'b0;
            vld_p2_q <= 1'b0;
        end else begin
            sum_p1_q <= sum_p1_d;
            vld_p1_q <= bus.din_valid;
            res_p2_q <= res_p2_d;
            sat_p2_q <= sat_p2_d;
            vld_p2_q <= vld_p1_q;
        end
    end

    // Stage 3: FIFO write; a full FIFO without a same-cycle read loses the sample
    assign rd_en = bus.dout_ready && !fifo_empty;

    fir_out_fifo #(
        .DW    (DOUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .wr_en   (vld_p2_q),
        .wr_data (res_p2_q),
        .rd_en   (rd_en),
        .rd_data (fifo_rd),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .level   (bus.fifo_level)
    );

    assign bus.dout       = fifo_rd;
    assign bus.dout_valid = !fifo_empty;

    assign sat_ev  = vld_p2_q && sat_p2_q;
    assign drop_ev = vld_p2_q && fifo_full && !rd_en;

    always_comb begin
        sat_flag_d  = sat_ev  || (sat_flag_q  && !bus.clr_flags);
        drop_flag_d = drop_ev || (drop_flag_q && !bus.clr_flags);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_flag_q  <= 1'b0;
            drop_flag_q <= 1'b0;
        end else begin
            sat_flag_q  <= sat_flag_d;
            drop_flag_q <= drop_flag_d;
        end
    end

    assign bus.sat_flag  = sat_flag_q;
    assign bus.drop_flag = drop_flag_q;

`ifdef FIR_OUT_STATS_EN
    logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        sat_cnt_d  = cnt_next(sat_cnt_q,  sat_ev,  bus.clr_flags);
        drop_cnt_d = cnt_next(drop_cnt_q, drop_ev, bus.clr_flags);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            sat_cnt_q  <= sat_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.sat_cnt  = sat_cnt_q;
    assign bus.drop_cnt = drop_cnt_q;
`else
    assign bus.sat_cnt  = '0;
    assign bus.drop_cnt = '0;
`endif

endmodule

// File: tb/tb_fir_out_stage.sv
// Directed bench for fir_out_stage: reset, latency, rounding, saturation,
// overflow, full-with-read and a randomised backpressure run.
module tb_fir_out_stage;
    import fir_out_pkg::*;

`ifdef FIR_OUT_STATS_EN
    localparam logic [7:0] CNT2 = 8'd2;
    localparam logic [7:0] CNT1 = 8'd1;
`else
    localparam logic [7:0] CNT2 = 8'd0;
    localparam logic [7:0] CNT1 = 8'd0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    fir_out_stage_if bus ();

    fir_out_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic signed [38:0] v);
        bus.din       = v;
        bus.din_valid = 1'b1;
        tick();
        bus.din_valid = 1'b0;
    endtask

    function automatic logic signed [38:0] mk(input int k, input int f);
        return (39'(k) <<< 19) + 39'(f);
    endfunction

    initial begin : stim
        logic [15:0] q_exp[$];
        logic [15:0] prev_dout;
        logic        prev_stall, pend1, pend2, drove;
        int          sent, got, cyc, k, f;

        bus.din        = '0;
        bus.din_valid  = 1'b0;
        bus.dout_ready = 1'b0;
        bus.clr_flags  = 1'b0;
        reset          = 1'b1;
        tick();
        tick();
        chk("rst_dout_valid", bus.dout_valid, 0);
        chk("rst_level",      bus.fifo_level, 0);
        chk("rst_dout",       bus.dout,       0);
        chk("rst_sat_flag",   bus.sat_flag,   0);
        chk("rst_drop_flag",  bus.drop_flag,  0);
        chk("rst_sat_cnt",    bus.sat_cnt,    0);
        chk("rst_drop_cnt",   bus.drop_cnt,   0);
        reset = 1'b0;
        tick();

        // three samples buffered (one saturating), then reset mid-stream
        send(mk(10, 0));
        send(mk(11, 0));
        send(39'h3FFFFFFFFF);
        tick();
        tick();
        chk("buf_level",    bus.fifo_level, 3);
        chk("buf_dout",     bus.dout,       10);
        chk("buf_sat_flag", bus.sat_flag,   1);
        reset = 1'b1;
        tick();
        chk("mid_dout_valid", bus.dout_valid, 0);
        chk("mid_level",      bus.fifo_level, 0);
        chk("mid_sat_flag",   bus.sat_flag,   0);
        chk("mid_dout",       bus.dout,       0);
        reset = 1'b0;
        tick();

        // latency: visible after the third edge following the strobe
        send(mk(5, 0));
        chk("lat_edge1", bus.dout_valid, 0);
        tick();
        chk("lat_edge2", bus.dout_valid, 0);
        tick();
        chk("lat_edge3", bus.dout_valid, 1);
        chk("lat_dout",  bus.dout,       5);
        bus.dout_ready = 1'b1;
        tick();
        chk("lat_popped", bus.dout_valid, 0);

        // rounding with ready held high
        send(mk(5, 0));             tick(); tick();
        chk("rnd_exact_v", bus.dout_valid, 1);
        chk("rnd_exact",   bus.dout, 5);
        send(mk(5, 262144));        tick(); tick();
        chk("rnd_half_up", bus.dout, 6);
        send(-39'sd262144);         tick(); tick();
        chk("rnd_neg_half_v", bus.dout_valid, 1);
        chk("rnd_neg_half",   bus.dout, 0);
        send(-39'sd262145);         tick(); tick();
        chk("rnd_neg_one", bus.dout, 16'hFFFF);
        tick();
        chk("rnd_sat_flag", bus.sat_flag, 0);

        // saturation at both rails
        send(39'h3FFFFFFFFF);       tick(); tick();
        chk("sat_hi",      bus.dout,     SAT_MAX);
        chk("sat_hi_flag", bus.sat_flag, 1);
        send(39'h4000000000);       tick(); tick();
        chk("sat_lo", bus.dout, SAT_MIN);
        tick();
        chk("sat_cnt2",      bus.sat_cnt,   CNT2);
        chk("sat_drop_flag", bus.drop_flag, 0);
        bus.clr_flags = 1'b1;
        tick();
        bus.clr_flags = 1'b0;
        chk("sat_clr_flag", bus.sat_flag, 0);
        chk("sat_clr_cnt",  bus.sat_cnt,  0);

        // clear coinciding with a saturation event: the event wins
        send(39'h3FFFFFFFFF);
        tick();
        bus.clr_flags = 1'b1;
        tick();
        bus.clr_flags = 1'b0;
        chk("clr_vs_ev_flag", bus.sat_flag, 1);
        chk("clr_vs_ev_cnt",  bus.sat_cnt,  CNT1);
        bus.clr_flags = 1'b1;
        tick();
        bus.clr_flags = 1'b0;
        chk("clr_again_flag", bus.sat_flag, 0);

        // overflow: six writes into a stalled four-entry FIFO
        bus.dout_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(mk(100 + i, 0));
        tick();
        tick();
        chk("ovf_level",     bus.fifo_level, 4);
        chk("ovf_drop_flag", bus.drop_flag,  1);
        chk("ovf_drop_cnt",  bus.drop_cnt,   CNT2);
        chk("ovf_sat_flag",  bus.sat_flag,   0);
        bus.dout_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("ovf_drain_v", bus.dout_valid, 1);
            chk("ovf_drain",   bus.dout,       100 + i);
            tick();
        end
        chk("ovf_empty", bus.dout_valid, 0);
        bus.clr_flags = 1'b1;
        tick();
        bus.clr_flags = 1'b0;
        chk("ovf_clr_flag", bus.drop_flag, 0);
        chk("ovf_clr_cnt",  bus.drop_cnt,  0);

        // full FIFO with a read in the same cycle as the fifth write
        bus.dout_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(mk(200 + i, 0));
        tick();
        chk("fr_level_pre", bus.fifo_level, 4);
        bus.dout_ready = 1'b1;
        tick();
        bus.dout_ready = 1'b0;
        chk("fr_level",     bus.fifo_level, 4);
        chk("fr_drop_flag", bus.drop_flag,  0);
        chk("fr_head",      bus.dout,       201);
        tick();
        chk("fr_stall_hold", bus.dout, 201);
        bus.dout_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            chk("fr_drain", bus.dout, 200 + i);
            tick();
        end
        chk("fr_empty", bus.dout_valid, 0);

        // random backpressure; stimulus gated so the FIFO never overflows
        prev_stall = 1'b0;
        prev_dout  = '0;
        pend1      = 1'b0;
        pend2      = 1'b0;
        sent       = 0;
        got        = 0;
        cyc        = 0;
        while (got < 1000 && cyc < 20000) begin
            if (prev_stall) begin
                chk("bp_hold_valid", bus.dout_valid, 1);
                chk("bp_hold_dout",  bus.dout,       prev_dout);
            end
            bus.dout_ready = 1'($urandom_range(1));
            if (bus.dout_valid && bus.dout_ready) begin
                if (q_exp.size() == 0) begin
                    chk("bp_extra_out", 64'(q_exp.size()), 1);
                end else begin
                    chk("bp_dout", bus.dout, q_exp.pop_front());
                    got++;
                end
            end
            prev_stall = bus.dout_valid && !bus.dout_ready;
            prev_dout  = bus.dout;
            drove = 1'b0;
            if (sent < 1000 && (int'(bus.fifo_level) + int'(pend1) + int'(pend2) + 1 <= 4)
                && $urandom_range(1) == 1) begin
                k = int'($urandom_range(60000)) - 30000;
                f = int'($urandom_range(524287));
                bus.din = mk(k, f);
                q_exp.push_back(16'(k + ((f >= 262144) ? 1 : 0)));
                drove = 1'b1;
                sent++;
            end
            bus.din_valid = drove;
            pend2 = pend1;
            pend1 = drove;
            tick();
            cyc++;
        end
        bus.din_valid = 1'b0;
        chk("bp_received",  got,           1000);
        chk("bp_drop_flag", bus.drop_flag, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
